// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO, parity, 1/2 stop bits and runtime prescaler
module uart_tx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    output logic                      Ready,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int BCW  = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                    r_state, w_next;
    logic [DATA_WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]             r_wptr, r_rptr;
    logic [CNTW-1:0]           r_count;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic [BCW-1:0]            r_bit_cnt;
    logic [PRESCALE_WIDTH-1:0] r_presc_cnt, r_pm1;
    logic                      r_par, r_par_en, r_stop2, r_stop_cnt, r_tx;

    logic                      w_push, w_pop, w_tx_next, w_shift, w_bit_adv, w_stop_set;
    logic                      w_bit_end, w_bit_last, w_has_data;
    logic [DATA_WIDTH-1:0]     w_head;
    logic [PRESCALE_WIDTH-1:0] w_pm1;

    assign Ready      = (r_count != CNTW'(FIFO_DEPTH));
    assign busy       = (r_state != S_IDLE) || (r_count != '0);
    assign TX_OUT     = r_tx;
    assign w_push     = Data_Valid && Ready;
    assign w_has_data = (r_count != '0);
    assign w_head     = r_mem[r_rptr];
    assign w_pm1      = (Prescale == '0) ? '0 : Prescale - PRESCALE_WIDTH'(1);
    assign w_bit_end  = (r_presc_cnt == r_pm1);
    assign w_bit_last = (r_bit_cnt == BCW'(DATA_WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_tx_next  = r_tx;
        w_shift    = 1'b0;
        w_bit_adv  = 1'b0;
        w_stop_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (w_has_data) begin
                    w_pop     = 1'b1;
                    w_tx_next = 1'b0;
                    w_next    = S_START;
                end
            end
            S_START: if (w_bit_end) begin
                w_bit_adv = 1'b1;
                w_tx_next = r_shift[0];
                w_next    = S_DATA;
            end
            S_DATA: if (w_bit_end) begin
                w_bit_adv = 1'b1;
                if (!w_bit_last) begin
                    w_shift   = 1'b1;
                    w_tx_next = r_shift[1];
                end else if (r_par_en) begin
                    w_tx_next = r_par;
                    w_next    = S_PARITY;
                end else begin
                    w_tx_next = 1'b1;
                    w_next    = S_STOP;
                end
            end
            S_PARITY: if (w_bit_end) begin
                w_bit_adv = 1'b1;
                w_tx_next = 1'b1;
                w_next    = S_STOP;
            end
            S_STOP: if (w_bit_end) begin
                w_bit_adv = 1'b1;
                if (r_stop2 && !r_stop_cnt) begin
                    w_stop_set = 1'b1;
                end else if (w_has_data) begin
                    // next frame starts on this edge so the line never idles between frames
                    w_pop     = 1'b1;
                    w_tx_next = 1'b0;
                    w_next    = S_START;
                end else begin
                    w_tx_next = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= P_DATA;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // frame configuration is captured at the pop so mid-frame input changes are ignored
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_tx        <= 1'b1;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_presc_cnt <= '0;
            r_pm1       <= '0;
            r_par       <= 1'b0;
            r_par_en    <= 1'b0;
            r_stop2     <= 1'b0;
            r_stop_cnt  <= 1'b0;
        end else begin
            r_tx <= w_tx_next;
            if (w_pop) begin
                r_shift     <= w_head;
                r_par       <= (^w_head) ^ PAR_TYP;
                r_par_en    <= PAR_EN;
                r_stop2     <= STOP2;
                r_pm1       <= w_pm1;
                r_bit_cnt   <= '0;
                r_presc_cnt <= '0;
                r_stop_cnt  <= 1'b0;
            end else if (w_bit_adv) begin
                r_presc_cnt <= '0;
                if (w_shift) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= r_bit_cnt + BCW'(1);
                end
                if (w_stop_set) r_stop_cnt <= 1'b1;
            end else if (r_state != S_IDLE) begin
                r_presc_cnt <= r_presc_cnt + PRESCALE_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo checking the serial line every cycle
module tb_uart_tx_fifo;
    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  P_DATA;
    logic        Data_Valid;
    logic        Ready;
    logic        PAR_EN, PAR_TYP, STOP2;
    logic [15:0] Prescale;
    logic        TX_OUT;
    logic        busy;

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];
    logic mon_en = 1'b0;
    bit   mon_active = 1'b0;

    uart_tx_fifo dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Ready(Ready),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .Prescale(Prescale),
        .TX_OUT(TX_OUT), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // line monitor: once a start bit appears, every cycle is matched against the expected queue
    initial begin
        logic e;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (!mon_active && exp_q.size() > 0 && TX_OUT === 1'b0) mon_active = 1'b1;
                if (mon_active) begin
                    e = exp_q.pop_front();
                    total++;
                    if (TX_OUT !== e) begin
                        bad++;
                        $display("FAIL tx_bit t=%0t got=%b want=%b left=%0d", $time, TX_OUT, e, exp_q.size());
                    end
                    if (exp_q.size() == 0) mon_active = 1'b0;
                end else if (exp_q.size() == 0) begin
                    total++;
                    if (TX_OUT !== 1'b1) begin
                        bad++;
                        $display("FAIL idle_line t=%0t got=%b want=1", $time, TX_OUT);
                    end
                end
            end
        end
    end

    task automatic add_bits(input string s, input logic [15:0] p);
        int pc;
        pc = (p == 0) ? 1 : int'(p);
        for (int i = 0; i < s.len(); i++)
            for (int k = 0; k < pc; k++) exp_q.push_back(s[i] == 8'h31);
    endtask

    task automatic add_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic s2, input logic [15:0] p);
        string s;
        s = "0";
        for (int i = 0; i < 8; i++) s = {s, d[i] ? "1" : "0"};
        if (pe) s = {s, ((^d) ^ pt) ? "1" : "0"};
        s = {s, "1"};
        if (s2) s = {s, "1"};
        add_bits(s, p);
    endtask

    task automatic push_word(input logic [7:0] d, input logic pe, input logic pt, input logic s2,
                             input logic [15:0] p, input string lit, output int waited);
        @(negedge CLK);
        P_DATA = d; Data_Valid = 1'b1; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; Prescale = p;
        waited = 0;
        while (Ready !== 1'b1 && waited < 300) begin
            @(negedge CLK);
            waited++;
        end
        if (waited >= 300) begin
            total++; bad++;
            $display("FAIL push_timeout data=%h ready=%b want=1", d, Ready);
        end
        @(posedge CLK);
        if (lit.len() > 0) add_bits(lit, p);
        else add_frame(d, pe, pt, s2, p);
        #1;
    endtask

    task automatic drop_valid();
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output int busy_low);
        int c;
        c = 0;
        busy_low = 0;
        forever begin
            @(negedge CLK); #1;
            c++;
            if (busy !== 1'b1) busy_low++;
            if (exp_q.size() == 0 && !mon_active) break;
            if (c > budget) begin
                total++; bad++;
                $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
                exp_q.delete();
                mon_active = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 16'd1;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (TX_OUT !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", TX_OUT); end
        total++; if (Ready !== 1'b1)  begin bad++; $display("FAIL reset_ready got=%b want=1", Ready); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(negedge CLK);
        RST = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_parity_even();
        int w, bl;
        push_word(8'h8F, 1'b1, 1'b0, 1'b0, 16'd4, "01111000111", w);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_push got=%b want=1", busy); end
        drop_valid();
        wait_drain(200, bl);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_last_stop got=%b want=1", busy); end
        @(posedge CLK); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_drop got=%b want=0", busy); end
    endtask

    task automatic test_fast_and_odd();
        int w, bl;
        push_word(8'hA8, 1'b0, 1'b0, 1'b0, 16'd1, "0000101011", w);
        drop_valid();
        wait_drain(100, bl);
        push_word(8'h8F, 1'b1, 1'b1, 1'b0, 16'd1, "01111000101", w);
        drop_valid();
        wait_drain(100, bl);
    endtask

    task automatic test_back_to_back();
        int w, bl;
        for (int i = 1; i <= 5; i++) begin
            push_word(8'(i), 1'b0, 1'b0, 1'b0, 16'd2, "", w);
            total++;
            if (w != 0) begin bad++; $display("FAIL b2b_stall word=%0d got=%0d want=0", i, w); end
        end
        total++; if (Ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b want=0", Ready); end
        push_word(8'h06, 1'b0, 1'b0, 1'b0, 16'd2, "", w);
        total++; if (w < 1) begin bad++; $display("FAIL b2b_sixth_wait got=%0d want>0", w); end
        drop_valid();
        wait_drain(400, bl);
        total++; if (bl != 0) begin bad++; $display("FAIL b2b_busy_low got=%0d want=0", bl); end
    endtask

    task automatic test_stop2_config();
        int w, bl;
        push_word(8'h00, 1'b1, 1'b0, 1'b1, 16'd3, "000000000011", w);
        drop_valid();
        repeat (6) @(negedge CLK);
        PAR_EN = 1'b0; STOP2 = 1'b0; PAR_TYP = 1'b1; Prescale = 16'd1;
        wait_drain(100, bl);
    endtask

    task automatic test_prescale_zero();
        int w, bl;
        push_word(8'h55, 1'b0, 1'b0, 1'b0, 16'd0, "0101010101", w);
        drop_valid();
        wait_drain(100, bl);
    endtask

    task automatic test_reset_midframe();
        int w, anomalies;
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) push_word(8'hC3 + 8'(i), 1'b1, 1'b0, 1'b0, 16'd4, "", w);
        drop_valid();
        repeat (10) @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        total++; if (TX_OUT !== 1'b1) begin bad++; $display("FAIL mid_rst_tx got=%b want=1", TX_OUT); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
        total++; if (Ready !== 1'b1)  begin bad++; $display("FAIL mid_rst_ready got=%b want=1", Ready); end
        @(negedge CLK);
        RST = 1'b1;
        exp_q.delete();
        mon_active = 1'b0;
        mon_en = 1'b1;
        anomalies = 0;
        repeat (100) begin
            @(negedge CLK);
            if (TX_OUT !== 1'b1 || busy !== 1'b0) anomalies++;
        end
        total++; if (anomalies != 0) begin bad++; $display("FAIL mid_rst_quiet got=%0d want=0", anomalies); end
    endtask

    initial begin
        test_reset();
        test_parity_even();
        test_fast_and_odd();
        test_back_to_back();
        test_stop2_config();
        test_prescale_zero();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
